samp_frame_readout: RTL and testbench
=====================================

SAMP_FRAME_READOUT -- requirements
Module: samp_frame_readout

Interface
REQ-001 SHALL have port CLK  in  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port SAMP_MAX  in  7  index of the last sample per event (samples 0..SAMP_MAX).
REQ-004 SHALL have port EVT_NUM  in  12  event number, placed in the frame header.
REQ-005 SHALL have port FIFO_EMPTY  in  1  sample FIFO empty flag (first-word-fall-through FIFO).
REQ-006 SHALL have port FIFO_DOUT  in  16  FIFO head word, valid whenever FIFO_EMPTY=0.
REQ-007 SHALL have port FIFO_RDEN  out  1  pops the FIFO head word in the same cycle.
REQ-008 SHALL have port DOUT  out  16  frame word to the link.
REQ-009 SHALL have port DVALID  out  1  DOUT holds a valid word.
REQ-010 SHALL have port DREADY  in  1  downstream accepts DOUT; a transfer occurs when DVALID=1 and DREADY=1.
REQ-011 SHALL have port BUSY  out  1  high whenever state is not Idle.
REQ-012 SHALL have port TMR_ERR_COUNT  out  16  TMR disagreement counter (see Configuration).

Function
REQ-013 SHALL implement states Idle, Header, Data, Trl_Cnt, Trl_Chk.
REQ-014 Output slot SHALL be "free" when DVALID=0 or DREADY=1; DOUT/DVALID SHALL load only when free, and SHALL hold otherwise.
REQ-015 Idle->Header SHALL occur when FIFO_EMPTY=0; on this edge SAMP_MAX and EVT_NUM SHALL be latched, the word count and checksum cleared.
REQ-016 Header SHALL present DOUT={4'hA,latched EVT_NUM}, DVALID=1, one cycle after FIFO_EMPTY falls in Idle; on a free slot it SHALL go to Data.
REQ-017 Expected data words N SHALL equal (latched SAMP_MAX+1)*6, with width 10 bits (max 768).
REQ-018 In Data, FIFO_RDEN SHALL be 1 exactly when FIFO_EMPTY=0 and the slot is free; the popped word SHALL load DOUT next edge with DVALID=1, count+1, checksum^=word.
REQ-019 In Data with FIFO_EMPTY=1, the block SHALL wait with no pop and no timeout; DVALID drops once the held word transfers.
REQ-020 On the pop of word N, the state SHALL go to Trl_Cnt; FIFO_RDEN SHALL never assert outside Data and never exceed N pops per frame.
REQ-021 Trl_Cnt SHALL present {4'hE,2'b00,count[9:0]}; on a free slot it SHALL go to Trl_Chk.
REQ-022 Trl_Chk SHALL present the 16-bit XOR of all N data words; on a free slot it SHALL go to Idle.
REQ-023 Idle SHALL drop DVALID once the trailer transfers; a new frame SHALL not start until the state is Idle (minimum 1 cycle between frames).
REQ-024 SAMP_MAX/EVT_NUM changes mid-frame SHALL have no effect on the current frame.
REQ-025 The back-to-back case (DREADY held 1, FIFO never empty) SHALL sustain one word per cycle: header, N data words and 2 trailers in N+3 consecutive cycles.

Reset
REQ-026 RST SHALL force state Idle, DVALID=0, DOUT=16'h0000, FIFO_RDEN=0, BUSY=0, count=0, checksum=0, TMR_ERR_COUNT=0.
REQ-027 RST mid-frame SHALL abandon the frame with no trailer and leave the FIFO contents untouched; the next frame SHALL start from whatever the FIFO holds.

Configuration
REQ-028 Macro SAMP_RDO_TMR_EN defined: state, count, checksum and DOUT/DVALID registers SHALL be triplicated with majority voting feeding each copy's next value; TMR_ERR_COUNT SHALL increment (saturating at 16'hFFFF) on each cycle any triplet disagrees.
REQ-029 Macro SAMP_RDO_TMR_EN undefined: registers SHALL be single copy and TMR_ERR_COUNT SHALL be constant 16'h0000; frame behaviour SHALL be identical.

Structure
REQ-030 Package samp_rdo_pkg SHALL hold the state encoding, the header/trailer markers 4'hA/4'hE, and CHANS_PER_SAMP=6.
REQ-031 Sub-module tmr_vote (parameter WIDTH; three inputs -> voted output plus disagree flag) SHALL be used for every triplicated register.

Verification
REQ-032 SAMP_MAX=0, EVT_NUM=12'h123, 6 words 16'h0001..16'h0006 preloaded, DREADY=1 -> A123,0001..0006,E006,0007 in 9 consecutive cycles.
REQ-033 SAMP_MAX=127, 768 words, DREADY=1 -> 771 words; count trailer E300; exactly 768 FIFO_RDEN pulses.
REQ-034 SAMP_MAX=1, DREADY toggling 1/0 each cycle -> no word duplicated or lost; DOUT held stable while DREADY=0.
REQ-035 FIFO empties after word 3 of 6 for 10 cycles -> no pop while empty, the frame resumes and the trailer equals E006.
REQ-036 RST asserted during Data word 4 -> DVALID=0 same cycle; after release, the 2 leftover words start a new frame with a header.
REQ-037 With SAMP_RDO_TMR_EN, force one state copy wrong for 1 cycle -> frame unaffected; TMR_ERR_COUNT=1.

Source files
------------

// File: rtl/samp_rdo_pkg.sv
// Shared types and constants for the sample frame readout: state encoding,
// frame markers and frame-length helper.
package samp_rdo_pkg;

   localparam int unsigned CHANS_PER_SAMP = 6;
   localparam int unsigned SAMP_W         = 7;
   localparam int unsigned EVT_W          = 12;
   localparam int unsigned WORD_W         = 16;
   localparam int unsigned CNT_W          = 10;
   localparam int unsigned ST_W           = 3;
   localparam int unsigned ERR_W          = 16;

   localparam logic [3:0] HDR_MARK = 4'hA;
   localparam logic [3:0] TRL_MARK = 4'hE;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_HEADER  = 3'd1,
      ST_DATA    = 3'd2,
      ST_TRL_CNT = 3'd3,
      ST_TRL_CHK = 3'd4
   } state_t;

   // Data words per frame: (samp_max + 1) samples of CHANS_PER_SAMP channels.
   function automatic logic [CNT_W-1:0] words_per_frame(input logic [SAMP_W-1:0] samp_max);
      return CNT_W'((32'(samp_max) + 32'd1) * CHANS_PER_SAMP);
   endfunction

endpackage

// File: rtl/samp_frame_readout_tmr_vote.sv
// Bitwise 2-of-3 majority voter with a flag raised when the three copies differ.
module tmr_vote #(
   parameter int unsigned WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] y,
   output logic             disagree
);

   assign y        = (a & b) | (a & c) | (b & c);
   assign disagree = (a != b) || (a != c);

endmodule

// File: rtl/samp_frame_readout.sv
// Reads one event's samples from a FWFT FIFO and emits a framed stream:
// header, N data words, count trailer, XOR checksum trailer.
// Define SAMP_RDO_TMR_EN to triplicate the frame registers with majority voting.
module samp_frame_readout
   import samp_rdo_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic [SAMP_W-1:0] SAMP_MAX,
   input  logic [EVT_W-1:0]  EVT_NUM,
   input  logic              FIFO_EMPTY,
   input  logic [WORD_W-1:0] FIFO_DOUT,
   output logic              FIFO_RDEN,
   output logic [WORD_W-1:0] DOUT,
   output logic              DVALID,
   input  logic              DREADY,
   output logic              BUSY,
   output logic [ERR_W-1:0]  TMR_ERR_COUNT
);

   logic [EVT_W-1:0]  evt_q;
   logic [CNT_W-1:0]  nwords_q;

   state_t            st_v, st_n;
   logic [CNT_W-1:0]  cnt_v, cnt_n, cnt_inc;
   logic [WORD_W-1:0] chk_v, chk_n;
   logic [WORD_W-1:0] dout_v, dout_n;
   logic              dv_v, dv_n;

   logic              slot_free;
   logic              latch_c;
   logic              rden_c;

   assign slot_free = !dv_v || DREADY;
   assign cnt_inc   = cnt_v + CNT_W'(1);

   // Frame parameters captured at frame start; later input changes are ignored.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         evt_q    <= '0;
         nwords_q <= '0;
      end else if (latch_c) begin
         evt_q    <= EVT_NUM;
         nwords_q <= words_per_frame(SAMP_MAX);
      end
   end

   // Next-state and next-output logic, computed from the (voted) current values.
   always_comb begin
      st_n    = st_v;
      cnt_n   = cnt_v;
      chk_n   = chk_v;
      dout_n  = dout_v;
      dv_n    = dv_v;
      rden_c  = 1'b0;
      latch_c = 1'b0;
      case (st_v)
         ST_IDLE: begin
            if (slot_free) dv_n = 1'b0;
            if (!FIFO_EMPTY) begin
               st_n    = ST_HEADER;
               cnt_n   = '0;
               chk_n   = '0;
               latch_c = 1'b1;
            end
         end
         ST_HEADER: begin
            if (slot_free) begin
               dout_n = {HDR_MARK, evt_q};
               dv_n   = 1'b1;
               st_n   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (slot_free) begin
               if (!FIFO_EMPTY) begin
                  rden_c = 1'b1;
                  dout_n = FIFO_DOUT;
                  dv_n   = 1'b1;
                  cnt_n  = cnt_inc;
                  chk_n  = chk_v ^ FIFO_DOUT;
                  if (cnt_inc == nwords_q) st_n = ST_TRL_CNT;
               end else begin
                  dv_n = 1'b0;
               end
            end
         end
         ST_TRL_CNT: begin
            if (slot_free) begin
               dout_n = {TRL_MARK, 2'b00, cnt_v};
               dv_n   = 1'b1;
               st_n   = ST_TRL_CHK;
            end
         end
         ST_TRL_CHK: begin
            if (slot_free) begin
               dout_n = chk_v;
               dv_n   = 1'b1;
               st_n   = ST_IDLE;
            end
         end
         default: st_n = ST_IDLE;
      endcase
   end

`ifdef SAMP_RDO_TMR_EN
   state_t            st_q0, st_q1, st_q2;
   logic [CNT_W-1:0]  cnt_q0, cnt_q1, cnt_q2;
   logic [WORD_W-1:0] chk_q0, chk_q1, chk_q2;
   logic [WORD_W-1:0] dout_q0, dout_q1, dout_q2;
   logic              dv_q0, dv_q1, dv_q2;
   logic [ST_W-1:0]   st_vote;
   logic [4:0]        dis;
   logic [ERR_W-1:0]  err_q;

   // Every copy reloads from the voted next value, so a single upset heals in one cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         st_q0   <= ST_IDLE;  st_q1   <= ST_IDLE;  st_q2   <= ST_IDLE;
         cnt_q0  <= '0;       cnt_q1  <= '0;       cnt_q2  <= '0;
         chk_q0  <= '0;       chk_q1  <= '0;       chk_q2  <= '0;
         dout_q0 <= '0;       dout_q1 <= '0;       dout_q2 <= '0;
         dv_q0   <= 1'b0;     dv_q1   <= 1'b0;     dv_q2   <= 1'b0;
      end else begin
         st_q0   <= st_n;     st_q1   <= st_n;     st_q2   <= st_n;
         cnt_q0  <= cnt_n;    cnt_q1  <= cnt_n;    cnt_q2  <= cnt_n;
         chk_q0  <= chk_n;    chk_q1  <= chk_n;    chk_q2  <= chk_n;
         dout_q0 <= dout_n;   dout_q1 <= dout_n;   dout_q2 <= dout_n;
         dv_q0   <= dv_n;     dv_q1   <= dv_n;     dv_q2   <= dv_n;
      end
   end

   tmr_vote #(.WIDTH(ST_W)) u_vote_st (
      .a(st_q0), .b(st_q1), .c(st_q2), .y(st_vote), .disagree(dis[0])
   );
   tmr_vote #(.WIDTH(CNT_W)) u_vote_cnt (
      .a(cnt_q0), .b(cnt_q1), .c(cnt_q2), .y(cnt_v), .disagree(dis[1])
   );
   tmr_vote #(.WIDTH(WORD_W)) u_vote_chk (
      .a(chk_q0), .b(chk_q1), .c(chk_q2), .y(chk_v), .disagree(dis[2])
   );
   tmr_vote #(.WIDTH(WORD_W)) u_vote_dout (
      .a(dout_q0), .b(dout_q1), .c(dout_q2), .y(dout_v), .disagree(dis[3])
   );
   tmr_vote #(.WIDTH(1)) u_vote_dv (
      .a(dv_q0), .b(dv_q1), .c(dv_q2), .y(dv_v), .disagree(dis[4])
   );

   assign st_v = state_t'(st_vote);

   // Saturating count of cycles with any triplet in disagreement.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                                  err_q <= '0;
      else if (|dis && (err_q != {ERR_W{1'b1}})) err_q <= err_q + ERR_W'(1);
   end

   assign TMR_ERR_COUNT = err_q;
`else
   state_t            st_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [WORD_W-1:0] chk_q;
   logic [WORD_W-1:0] dout_q;
   logic              dv_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         st_q   <= ST_IDLE;
         cnt_q  <= '0;
         chk_q  <= '0;
         dout_q <= '0;
         dv_q   <= 1'b0;
      end else begin
         st_q   <= st_n;
         cnt_q  <= cnt_n;
         chk_q  <= chk_n;
         dout_q <= dout_n;
         dv_q   <= dv_n;
      end
   end

   assign st_v          = st_q;
   assign cnt_v         = cnt_q;
   assign chk_v         = chk_q;
   assign dout_v        = dout_q;
   assign dv_v          = dv_q;
   assign TMR_ERR_COUNT = '0;
`endif

   assign FIFO_RDEN = rden_c;
   assign DOUT      = dout_v;
   assign DVALID    = dv_v;
   assign BUSY      = (st_v != ST_IDLE);

endmodule

// File: tb/tb_samp_frame_readout.sv
// Directed bench for samp_frame_readout: FWFT FIFO model, transfer monitor,
// immediate-assertion checks. Covers the TMR upset case when SAMP_RDO_TMR_EN is defined.
module tb_samp_frame_readout;
   import samp_rdo_pkg::*;

   logic        CLK = 1'b0;
   logic        RST;
   logic [6:0]  SAMP_MAX;
   logic [11:0] EVT_NUM;
   logic        FIFO_EMPTY;
   logic [15:0] FIFO_DOUT;
   logic        FIFO_RDEN;
   logic [15:0] DOUT;
   logic        DVALID;
   logic        DREADY;
   logic        BUSY;
   logic [15:0] TMR_ERR_COUNT;

   samp_frame_readout dut (
      .CLK(CLK), .RST(RST), .SAMP_MAX(SAMP_MAX), .EVT_NUM(EVT_NUM),
      .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DOUT(FIFO_DOUT), .FIFO_RDEN(FIFO_RDEN),
      .DOUT(DOUT), .DVALID(DVALID), .DREADY(DREADY), .BUSY(BUSY),
      .TMR_ERR_COUNT(TMR_ERR_COUNT)
   );

   always #5 CLK = ~CLK;

   int          n_total = 0;
   int          n_pass  = 0;
   int          n_fail  = 0;
   logic [15:0] fifo_q[$];
   logic [15:0] dat_q[$];
   logic [15:0] exp_q[$];
   logic [15:0] rx_q[$];
   int          rx_cyc[$];
   int          cyc = 0;
   int          rden_cnt = 0;
   int          bad_pop = 0;
   int          stab_bad = 0;
   logic        held_v = 1'b0;
   logic [15:0] held_w = 16'h0000;
   logic        pop_now = 1'b0;

   task automatic upd_fifo();
      FIFO_EMPTY = (fifo_q.size() == 0);
      FIFO_DOUT  = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0000;
   endtask

   // Samples mid-cycle, pops the FIFO model just after the edge.
   initial begin
      forever begin
         @(negedge CLK); #3;
         cyc++;
         pop_now = FIFO_RDEN;
         if (FIFO_RDEN) begin
            rden_cnt++;
            if (FIFO_EMPTY) bad_pop++;
         end
         if (held_v && (!DVALID || DOUT !== held_w)) stab_bad++;
         held_v = DVALID && !DREADY;
         held_w = DOUT;
         if (DVALID && DREADY) begin
            rx_q.push_back(DOUT);
            rx_cyc.push_back(cyc);
         end
         @(posedge CLK); #1;
         if (pop_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
         upd_fifo();
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] rx_at(input int i);
      return (i < rx_q.size()) ? rx_q[i] : 16'hxxxx;
   endfunction

   function automatic int cyc_at(input int i);
      return (i < rx_cyc.size()) ? rx_cyc[i] : -1000;
   endfunction

   task automatic wait_rx(input int n, input int budget, input string tag);
      int k = 0;
      while (rx_q.size() < n && k < budget) begin
         @(negedge CLK);
         k++;
      end
      check({tag, "_arrived"}, 32'(rx_q.size() >= n), 32'd1);
   endtask

   task automatic exp_frame(input logic [11:0] evt);
      logic [15:0] x = 16'h0000;
      exp_q.delete();
      exp_q.push_back({4'hA, evt});
      foreach (dat_q[i]) begin
         exp_q.push_back(dat_q[i]);
         x ^= dat_q[i];
      end
      exp_q.push_back({4'hE, 2'b00, 10'(dat_q.size())});
      exp_q.push_back(x);
   endtask

   task automatic check_frame(input string tag);
      int mism = 0;
      check({tag, "_len"}, rx_q.size(), exp_q.size());
      if (exp_q.size() <= 16) begin
         for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), 32'(rx_at(i)), 32'(exp_q[i]));
      end else begin
         for (int i = 0; i < exp_q.size(); i++)
            if (rx_at(i) !== exp_q[i]) mism++;
         check({tag, "_mism"}, mism, 0);
      end
   endtask

   task automatic start_frame(input logic [6:0] sm, input logic [11:0] evt);
      rx_q.delete();
      rx_cyc.delete();
      rden_cnt = 0;
      SAMP_MAX = sm;
      EVT_NUM  = evt;
      @(negedge CLK);
      fifo_q = dat_q;
      upd_fifo();
   endtask

   initial begin
      int k;
      RST      = 1'b1;
      DREADY   = 1'b1;
      SAMP_MAX = 7'd0;
      EVT_NUM  = 12'h000;
      upd_fifo();
      repeat (3) @(negedge CLK);
      check("rst_dvalid", 32'(DVALID), 32'd0);
      check("rst_dout", 32'(DOUT), 32'h0000);
      check("rst_rden", 32'(FIFO_RDEN), 32'd0);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_tmr", 32'(TMR_ERR_COUNT), 32'h0000);
      RST = 1'b0;
      repeat (2) @(negedge CLK);

      // Smallest frame, back to back
      dat_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
      start_frame(7'd0, 12'h123);
      wait_rx(9, 40, "t1");
      exp_frame(12'h123);
      check_frame("t1");
      check("t1_hdr", 32'(rx_at(0)), 32'hA123);
      check("t1_trl_cnt", 32'(rx_at(7)), 32'hE006);
      check("t1_trl_chk", 32'(rx_at(8)), 32'h0007);
      check("t1_span", cyc_at(8) - cyc_at(0), 8);
      check("t1_pops", rden_cnt, 6);
      repeat (3) @(negedge CLK);
      check("t1_idle_busy", 32'(BUSY), 32'd0);
      check("t1_idle_dv", 32'(DVALID), 32'd0);

      // Largest frame, inputs changed mid-frame
      dat_q.delete();
      for (int i = 0; i < 768; i++) dat_q.push_back(16'(i * 257 + 16'h3C5A));
      start_frame(7'd127, 12'hFED);
      wait_rx(1, 20, "t2_hdr");
      SAMP_MAX = 7'd0;
      EVT_NUM  = 12'h000;
      wait_rx(771, 900, "t2");
      exp_frame(12'hFED);
      check_frame("t2");
      check("t2_hdr", 32'(rx_at(0)), 32'hAFED);
      check("t2_trl_cnt", 32'(rx_at(769)), 32'hE300);
      check("t2_span", cyc_at(770) - cyc_at(0), 770);
      check("t2_pops", rden_cnt, 768);
      repeat (3) @(negedge CLK);
      check("t2_idle_busy", 32'(BUSY), 32'd0);

      // Downstream backpressure toggling every cycle
      dat_q.delete();
      for (int i = 0; i < 12; i++) dat_q.push_back(16'(16'h2000 + i));
      stab_bad = 0;
      start_frame(7'd1, 12'h034);
      k = 0;
      while (rx_q.size() < 15 && k < 200) begin
         @(negedge CLK);
         DREADY = ~DREADY;
         k++;
      end
      DREADY = 1'b1;
      wait_rx(15, 10, "t3");
      exp_frame(12'h034);
      check_frame("t3");
      check("t3_trl_cnt", 32'(rx_at(13)), 32'hE00C);
      check("t3_stable", stab_bad, 0);
      check("t3_pops", rden_cnt, 12);
      repeat (3) @(negedge CLK);

      // FIFO runs dry after word 3, then refills
      dat_q = '{16'h0011, 16'h0022, 16'h0033};
      bad_pop = 0;
      start_frame(7'd0, 12'h0C4);
      wait_rx(4, 20, "t4a");
      repeat (10) @(negedge CLK);
      check("t4_no_pop_empty", bad_pop, 0);
      check("t4_pops_stall", rden_cnt, 3);
      check("t4_busy_stall", 32'(BUSY), 32'd1);
      check("t4_dv_stall", 32'(DVALID), 32'd0);
      fifo_q = '{16'h0044, 16'h0055, 16'h0066};
      upd_fifo();
      wait_rx(9, 30, "t4");
      dat_q = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066};
      exp_frame(12'h0C4);
      check_frame("t4");
      check("t4_trl_cnt", 32'(rx_at(7)), 32'hE006);
      check("t4_trl_chk", 32'(rx_at(8)), 32'h0077);
      check("t4_pops", rden_cnt, 6);
      repeat (3) @(negedge CLK);

      // Reset while data word 4 is on the output
      dat_q = '{16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0106};
      start_frame(7'd0, 12'h0AB);
      k = 0;
      while (!(DVALID && DOUT == 16'h0104) && k < 40) begin
         @(negedge CLK);
         k++;
      end
      check("t5_reached_w4", 32'(DOUT), 32'h0104);
      RST = 1'b1;
      #1;
      check("t5_rst_dv", 32'(DVALID), 32'd0);
      check("t5_rst_dout", 32'(DOUT), 32'h0000);
      check("t5_rst_rden", 32'(FIFO_RDEN), 32'd0);
      check("t5_rst_busy", 32'(BUSY), 32'd0);
      repeat (2) @(negedge CLK);
      check("t5_leftover", fifo_q.size(), 2);
      rx_q.delete();
      rx_cyc.delete();
      rden_cnt = 0;
      RST = 1'b0;
      wait_rx(3, 20, "t5a");
      repeat (3) @(negedge CLK);
      check("t5_hdr", 32'(rx_at(0)), 32'hA0AB);
      check("t5_busy_wait", 32'(BUSY), 32'd1);
      check("t5_partial_len", rx_q.size(), 3);
      fifo_q = '{16'h0107, 16'h0108, 16'h0109, 16'h010A};
      upd_fifo();
      wait_rx(9, 30, "t5");
      dat_q = '{16'h0105, 16'h0106, 16'h0107, 16'h0108, 16'h0109, 16'h010A};
      exp_frame(12'h0AB);
      check_frame("t5");
      check("t5_trl_chk", 32'(rx_at(8)), 32'h000F);
      repeat (3) @(negedge CLK);

`ifdef SAMP_RDO_TMR_EN
      // Single-cycle upset of one state copy
      dat_q = '{16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04, 16'h0A05, 16'h0A06};
      start_frame(7'd0, 12'h055);
      wait_rx(2, 20, "t6a");
      force dut.st_q1 = ST_IDLE;
      #1;
      release dut.st_q1;
      wait_rx(9, 30, "t6");
      exp_frame(12'h055);
      check_frame("t6");
      repeat (3) @(negedge CLK);
      check("t6_tmr_err", 32'(TMR_ERR_COUNT), 32'd1);
`else
      check("tmr_off_err", 32'(TMR_ERR_COUNT), 32'h0000);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
